// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
//   state_e                   : controller state encoding (IDLE, RUN, DONE)
//   SERIAL_ADD_WIDTH_DEFAULT  : default operand width
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// 1-bit combinational full adder used as the single arithmetic slice of the
// serial adder.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts a, b, cin over a valid/ready handshake,
// runs one full adder over WIDTH cycles LSB first, then presents sum, cout and
// signed overflow over a valid/ready result handshake.
//   clk, reset_n          : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, cin             : operands and carry-in
//   out_valid / out_ready : result handshake (out_valid in DONE)
//   sum, cout, ovf        : registered result, held until the next DONE
//   busy                  : high in RUN or DONE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one bit per cycle through the full adder, cnt = bit index
// DONE  | result presented, held until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] a_shift;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // The A shift register doubles as the sum shift register: each consumed
  // operand bit leaves at the LSB while the new sum bit enters at the MSB, so
  // after WIDTH cycles it holds the complete sum.
  if (WIDTH == 1) begin : g_shift_w1
    assign a_shift = fa_s;
  end else begin : g_shift_wn
    assign a_shift = {fa_s, a_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_shift;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB on this cycle.
          sum_d   = a_shift;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
